// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with register file, write-back bypass, load-use
// bubble insertion and ID/EX pipeline register. Optional macro: ID_ILLEGAL_TRAP_EN.
module id_stage_pipe #(
    parameter int PC_SIZE = 10,
    parameter int XLEN    = 8,
    parameter int NREGS   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     if_valid,
    input  logic [PC_SIZE-1:0]       if_pc,
    input  logic [31:0]              if_instr,
    output logic                     id_ready,
    input  logic                     ex_stall,
    input  logic                     flush,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     ex_valid,
    output logic [PC_SIZE-1:0]       ex_pc,
    output logic [XLEN-1:0]          ex_rs1_data,
    output logic [XLEN-1:0]          ex_rs2_data,
    output logic [11:0]              ex_imm,
    output logic [9:0]               ex_funct,
    output logic [$clog2(NREGS)-1:0] ex_rs1,
    output logic [$clog2(NREGS)-1:0] ex_rs2,
    output logic [$clog2(NREGS)-1:0] ex_rd,
    output logic                     ex_branch,
    output logic                     ex_mem_read,
    output logic                     ex_mem_to_reg,
    output logic                     ex_mem_write,
    output logic                     ex_alu_src,
    output logic                     ex_reg_write,
`ifdef ID_ILLEGAL_TRAP_EN
    output logic                     ex_illegal,
`endif
    output logic [1:0]               ex_alu_op
);

    localparam int RA_W = $clog2(NREGS);

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctl_t;

    typedef struct packed {
        logic               valid;
        logic [PC_SIZE-1:0] pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [11:0]        imm;
        logic [9:0]         funct;
        logic [RA_W-1:0]    rs1;
        logic [RA_W-1:0]    rs2;
        logic [RA_W-1:0]    rd;
        ctl_t               ctl;
`ifdef ID_ILLEGAL_TRAP_EN
        logic               illegal;
`endif
    } idex_t;

    idex_t           idex_q, idex_d;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    ctl_t            dec_ctl;
    logic [11:0]     dec_imm;
    logic            rs2_used;
    logic            known_op;
    logic [RA_W-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            hz;

    always_comb begin
        dec_ctl  = '0;
        dec_imm  = '0;
        rs2_used = 1'b0;
        known_op = 1'b1;
        rs1_idx  = RA_W'(if_instr[19:15]);
        rs2_idx  = RA_W'(if_instr[24:20]);
        rd_idx   = RA_W'(if_instr[11:7]);
        case (if_instr[6:0])
            7'b0110011: begin
                dec_ctl.alu_op    = 2'b10;
                dec_ctl.reg_write = 1'b1;
                rs2_used          = 1'b1;
            end
            7'b0010011: begin
                dec_ctl.alu_op    = 2'b10;
                dec_ctl.alu_src   = 1'b1;
                dec_ctl.reg_write = 1'b1;
                dec_imm           = if_instr[31:20];
            end
            7'b0000011: begin
                dec_ctl.alu_src    = 1'b1;
                dec_ctl.mem_read   = 1'b1;
                dec_ctl.mem_to_reg = 1'b1;
                dec_ctl.reg_write  = 1'b1;
                dec_imm            = if_instr[31:20];
            end
            7'b0100011: begin
                dec_ctl.alu_src   = 1'b1;
                dec_ctl.mem_write = 1'b1;
                dec_imm           = {if_instr[31:25], if_instr[11:7]};
                rs2_used          = 1'b1;
            end
            7'b1100011: begin
                dec_ctl.alu_op = 2'b01;
                dec_ctl.branch = 1'b1;
                dec_imm        = {if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8]};
                rs2_used       = 1'b1;
            end
            default: known_op = 1'b0;
        endcase
    end

    // Same-cycle write-back wins over the stored value so a dependent
    // instruction in ID never sees stale data.
    always_comb begin
        if (rs1_idx == '0)
            rs1_val = '0;
        else if (wb_en && (wb_rd != '0) && (wb_rd == rs1_idx))
            rs1_val = wb_data;
        else
            rs1_val = rf_q[rs1_idx];

        if (rs2_idx == '0)
            rs2_val = '0;
        else if (wb_en && (wb_rd != '0) && (wb_rd == rs2_idx))
            rs2_val = wb_data;
        else
            rs2_val = rf_q[rs2_idx];
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_rd != '0))
            rf_d[wb_rd] = wb_data;
    end

    assign hz = idex_q.valid && idex_q.ctl.mem_read && (idex_q.rd != '0) &&
                ((idex_q.rd == rs1_idx) || ((idex_q.rd == rs2_idx) && rs2_used));
    assign id_ready = !ex_stall && !hz;

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d.valid = 1'b0;
            idex_d.ctl   = '0;
`ifdef ID_ILLEGAL_TRAP_EN
            idex_d.illegal = 1'b0;
`endif
        end else if (ex_stall) begin
            idex_d = idex_q;
        end else if (hz) begin
            idex_d.valid = 1'b0;
            idex_d.ctl   = '0;
`ifdef ID_ILLEGAL_TRAP_EN
            idex_d.illegal = 1'b0;
`endif
        end else begin
            idex_d.valid    = if_valid;
            idex_d.pc       = if_pc;
            idex_d.rs1_data = rs1_val;
            idex_d.rs2_data = rs2_val;
            idex_d.imm      = dec_imm;
            idex_d.funct    = {if_instr[31:25], if_instr[14:12]};
            idex_d.rs1      = rs1_idx;
            idex_d.rs2      = rs2_idx;
            idex_d.rd       = rd_idx;
            idex_d.ctl      = if_valid ? dec_ctl : '0;
`ifdef ID_ILLEGAL_TRAP_EN
            idex_d.illegal  = if_valid && !known_op;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idex_q <= '0;
            rf_q   <= '{default: '0};
        end else begin
            idex_q <= idex_d;
            rf_q   <= rf_d;
        end
    end

    assign ex_valid      = idex_q.valid;
    assign ex_pc         = idex_q.pc;
    assign ex_rs1_data   = idex_q.rs1_data;
    assign ex_rs2_data   = idex_q.rs2_data;
    assign ex_imm        = idex_q.imm;
    assign ex_funct      = idex_q.funct;
    assign ex_rs1        = idex_q.rs1;
    assign ex_rs2        = idex_q.rs2;
    assign ex_rd         = idex_q.rd;
    assign ex_branch     = idex_q.ctl.branch;
    assign ex_mem_read   = idex_q.ctl.mem_read;
    assign ex_mem_to_reg = idex_q.ctl.mem_to_reg;
    assign ex_mem_write  = idex_q.ctl.mem_write;
    assign ex_alu_src    = idex_q.ctl.alu_src;
    assign ex_reg_write  = idex_q.ctl.reg_write;
    assign ex_alu_op     = idex_q.ctl.alu_op;
`ifdef ID_ILLEGAL_TRAP_EN
    assign ex_illegal    = idex_q.illegal;
`else
    logic unused_known;
    assign unused_known  = known_op;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed, table-driven bench for id_stage_pipe plus hand-written
// sequences for reset during stall and flush overriding a load-use hazard.
module tb_id_stage_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [9:0]  if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        ex_stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        ex_valid;
    logic [9:0]  ex_pc;
    logic [7:0]  ex_rs1_data, ex_rs2_data;
    logic [11:0] ex_imm;
    logic [9:0]  ex_funct;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
    logic [1:0]  ex_alu_op;
`ifdef ID_ILLEGAL_TRAP_EN
    logic        ex_illegal;
`endif

    int n_cmp = 0;
    int n_err = 0;

    id_stage_pipe #(.PC_SIZE(10), .XLEN(8), .NREGS(32)) dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .id_ready(id_ready), .ex_stall(ex_stall), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_funct(ex_funct), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
`ifdef ID_ILLEGAL_TRAP_EN
        .ex_illegal(ex_illegal),
`endif
        .ex_alu_op(ex_alu_op)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [9:0]  pc;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  wrd;
        logic [7:0]  wdat;
        logic        stall;
        logic        fl;
        logic        chk_data;
        logic        e_rdy;
        logic        e_vld;
        logic [7:0]  e_ctl;
        logic [7:0]  e_r1;
        logic [7:0]  e_r2;
        logic [11:0] e_imm;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rd;
        logic [9:0]  e_fun;
        logic [9:0]  e_pc;
        logic        e_ill;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] ctl_now();
        return {ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                ex_alu_src, ex_reg_write, ex_alu_op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic iv, input logic [9:0] pc, input logic [31:0] instr,
                          input logic stall, input logic fl);
        if_valid = iv;
        if_pc    = pc;
        if_instr = instr;
        ex_stall = stall;
        flush    = fl;
        wb_en    = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 10'd0, 32'h0, 1'b0, 1'b0);
        repeat (2) tick();

        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_pc",    {22'b0, ex_pc}, 32'd0);
        chk("rst_r1",    {24'b0, ex_rs1_data}, 32'd0);
        chk("rst_r2",    {24'b0, ex_rs2_data}, 32'd0);
        chk("rst_imm",   {20'b0, ex_imm}, 32'd0);
        chk("rst_fun",   {22'b0, ex_funct}, 32'd0);
        chk("rst_idx",   {17'b0, ex_rs1, ex_rs2, ex_rd}, 32'd0);
        chk("rst_ctl",   {24'b0, ctl_now()}, 32'd0);
        chk("rst_ready", {31'b0, id_ready}, 32'd1);
`ifdef ID_ILLEGAL_TRAP_EN
        chk("rst_ill",   {31'b0, ex_illegal}, 32'd0);
`endif
        reset = 1'b0;

        //            iv pc  instr         wen wrd wdat  st fl cd  rdy vld ctl    r1     r2     imm      rs1 rd fun      pc  ill
        tbl.push_back('{0, 0,  32'h00000013, 1, 5, 8'h3C, 0, 0, 1,  1, 0, 8'h00, 8'h00, 8'h00, 12'h000, 0, 0, 10'h000, 0,  0});
        tbl.push_back('{1, 4,  32'h00028333, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h06, 8'h3C, 8'h00, 12'h000, 5, 6, 10'h000, 4,  0});
        tbl.push_back('{1, 8,  32'h00338413, 1, 7, 8'hA5, 0, 0, 1,  1, 1, 8'h0E, 8'hA5, 8'h00, 12'h003, 7, 8, 10'h000, 8,  0});
        tbl.push_back('{1, 12, 32'h0000A203, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h6C, 8'h00, 8'h00, 12'h000, 1, 4, 10'h002, 12, 0});
        tbl.push_back('{1, 16, 32'h002204B3, 0, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 8'h00, 8'h00, 12'h000, 1, 4, 10'h002, 12, 0});
        tbl.push_back('{1, 16, 32'h002204B3, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h06, 8'h00, 8'h00, 12'h000, 4, 9, 10'h000, 16, 0});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{1, 20, 32'h00338413, 0, 0, 8'h00, 1, 0, 1,  0, 1, 8'h06, 8'h00, 8'h00, 12'h000, 4, 9, 10'h000, 16, 0});
        tbl.push_back('{1, 20, 32'h00338413, 0, 0, 8'h00, 1, 1, 0,  0, 0, 8'h00, 8'h00, 8'h00, 12'h000, 0, 0, 10'h000, 0,  0});
        tbl.push_back('{1, 24, 32'h05500513, 1, 0, 8'hFF, 0, 0, 1,  1, 1, 8'h0E, 8'h00, 8'h00, 12'h055, 0, 10, 10'h010, 24, 0});
        tbl.push_back('{1, 28, 32'h7E312A23, 1, 3, 8'h5A, 0, 0, 1,  1, 1, 8'h18, 8'h00, 8'h5A, 12'h7F4, 2, 20, 10'h1FA, 28, 0});
        tbl.push_back('{1, 32, 32'h00318463, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h81, 8'h5A, 8'h5A, 12'h004, 3, 8, 10'h000, 32, 0});
        tbl.push_back('{1, 36, 32'h00002383, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h6C, 8'h00, 8'h00, 12'h000, 0, 7, 10'h002, 36, 0});
        tbl.push_back('{1, 40, 32'h0071A023, 0, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 8'h00, 8'h00, 12'h000, 0, 7, 10'h002, 36, 0});
        tbl.push_back('{1, 40, 32'h0071A023, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h18, 8'h5A, 8'hA5, 12'h000, 3, 0, 10'h002, 40, 0});
        tbl.push_back('{1, 44, 32'h00002383, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h6C, 8'h00, 8'h00, 12'h000, 0, 7, 10'h002, 44, 0});
        tbl.push_back('{1, 48, 32'h00700413, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h0E, 8'h00, 8'hA5, 12'h007, 0, 8, 10'h000, 48, 0});
        tbl.push_back('{1, 52, 32'h0000007F, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h00, 8'h00, 8'h00, 12'h000, 0, 0, 10'h000, 52, 1});
        tbl.push_back('{0, 56, 32'h0000A083, 0, 0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 8'h00, 8'h00, 12'h000, 1, 1, 10'h002, 56, 0});
        tbl.push_back('{1, 60, 32'h00008133, 0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h06, 8'h00, 8'h00, 12'h000, 1, 2, 10'h000, 60, 0});

        foreach (tbl[i]) begin
            set_in(tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].stall, tbl[i].fl);
            wb_en   = tbl[i].wen;
            wb_rd   = tbl[i].wrd;
            wb_data = tbl[i].wdat;
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, id_ready}, {31'b0, tbl[i].e_rdy});
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, {31'b0, tbl[i].e_vld});
            chk($sformatf("v%0d_ctl", i), {24'b0, ctl_now()}, {24'b0, tbl[i].e_ctl});
            if (tbl[i].chk_data) begin
                chk($sformatf("v%0d_r1", i),  {24'b0, ex_rs1_data}, {24'b0, tbl[i].e_r1});
                chk($sformatf("v%0d_r2", i),  {24'b0, ex_rs2_data}, {24'b0, tbl[i].e_r2});
                chk($sformatf("v%0d_imm", i), {20'b0, ex_imm}, {20'b0, tbl[i].e_imm});
                chk($sformatf("v%0d_rs1", i), {27'b0, ex_rs1}, {27'b0, tbl[i].e_rs1});
                chk($sformatf("v%0d_rd", i),  {27'b0, ex_rd}, {27'b0, tbl[i].e_rd});
                chk($sformatf("v%0d_fun", i), {22'b0, ex_funct}, {22'b0, tbl[i].e_fun});
                chk($sformatf("v%0d_pc", i),  {22'b0, ex_pc}, {22'b0, tbl[i].e_pc});
            end
`ifdef ID_ILLEGAL_TRAP_EN
            chk($sformatf("v%0d_ill", i), {31'b0, ex_illegal}, {31'b0, tbl[i].e_ill});
`endif
        end

        // Reset arriving while a stall holds a valid load
        set_in(1'b1, 10'd100, 32'h0000A203, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 10'd104, 32'h002204B3, 1'b1, 1'b0);
        tick();
        chk("rs_hold_valid", {31'b0, ex_valid}, 32'd1);
        chk("rs_hold_pc", {22'b0, ex_pc}, 32'd100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ex_stall = 1'b0;
        chk("rs_valid", {31'b0, ex_valid}, 32'd0);
        chk("rs_ctl", {24'b0, ctl_now()}, 32'd0);
        chk("rs_pc", {22'b0, ex_pc}, 32'd0);
        set_in(1'b1, 10'd108, 32'h00028333, 1'b0, 1'b0);
        #1;
        chk("rs_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("rs_add_valid", {31'b0, ex_valid}, 32'd1);
        chk("rs_rf_cleared", {24'b0, ex_rs1_data}, 32'd0);
        chk("rs_add_rs1", {27'b0, ex_rs1}, 32'd5);

        // Flush beats a pending load-use hazard
        set_in(1'b1, 10'd112, 32'h0000A203, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 10'd116, 32'h002204B3, 1'b0, 1'b1);
        #1;
        chk("fl_hz_ready", {31'b0, id_ready}, 32'd0);
        tick();
        chk("fl_valid", {31'b0, ex_valid}, 32'd0);
        chk("fl_mem_read", {31'b0, ex_mem_read}, 32'd0);
        set_in(1'b1, 10'd116, 32'h002204B3, 1'b0, 1'b0);
        #1;
        chk("fl_ready_after", {31'b0, id_ready}, 32'd1);
        tick();
        chk("fl_add_valid", {31'b0, ex_valid}, 32'd1);
        chk("fl_add_rd", {27'b0, ex_rd}, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
